// File: rtl/sll_pkg.sv
// sll_pkg
// Shared definitions for the iterative 32-bit shift-left unit: datapath and
// shift-amount widths, where the shift amount lives inside the B operand for
// the SLL (fixed) and SLLV (variable) forms, and the FSM state type.
// Optional feature macro used by the files that import this package:
//   SLL32_ITER_OVF_EN - enables signed-overflow tracking on the ovf output.
package sll_pkg;

    localparam int DATA_W        = 32;
    localparam int SHAMT_W       = 5;
    localparam int SHAMT_FIX_LSB = 6;
    localparam int SHAMT_VAR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sll_step.sv
// sll_step
// Combinational single-iteration shifter. Shifts the incoming value left by
// min(i_cnt, STEP) positions and reports how many positions were used, so
// the caller can decrement its remaining-count register.
// With SLL32_ITER_OVF_EN defined it also reports o_mismatch: high when any
// bit shifted out of the top, or the new sign bit, differs from the old
// sign bit. Without the macro that port and its logic do not exist.
// Ports:
//   i_val      in  32  value to shift
//   i_cnt      in  5   remaining shift amount
//   o_val      out 32  shifted value, zero-filled from the right
//   o_used     out 5   shift amount applied this iteration
//   o_mismatch out 1   sign mismatch flag (macro builds only)
module sll_step
    import sll_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [DATA_W-1:0]  i_val,
    input  logic [SHAMT_W-1:0] i_cnt,
    output logic [DATA_W-1:0]  o_val,
    output logic [SHAMT_W-1:0] o_used
`ifdef SLL32_ITER_OVF_EN
    ,
    output logic               o_mismatch
`endif
);

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    logic [SHAMT_W-1:0] w_amt;

    assign w_amt  = (i_cnt < STEP_AMT) ? i_cnt : STEP_AMT;
    assign o_used = w_amt;
    assign o_val  = i_val << w_amt;

`ifdef SLL32_ITER_OVF_EN
    // Bits 31-1 .. 31-amt end up either shifted out or as the new sign bit;
    // the value stays representable only if all of them match the old sign.
    always_comb begin
        o_mismatch = 1'b0;
        for (int j = 1; j <= STEP; j++) begin
            if ((SHAMT_W'(j) <= w_amt) && (i_val[DATA_W-1-j] != i_val[DATA_W-1])) begin
                o_mismatch = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sll32_iter.sv
// sll32_iter
// Iterative 32-bit shift-left unit for the SLL/SLLV path. A start pulse in
// IDLE captures A and the shift amount; the SHIFT state then moves up to
// STEP bit positions per clock until the count is exhausted, and DONE
// publishes the result. The done pulse and the o/ovf registers update on the
// clock after DONE, at which point the FSM is already back in IDLE and can
// accept a new start.
// Optional feature macro: SLL32_ITER_OVF_EN (signed overflow tracking). When
// undefined the ovf port is tied low.
// Ports:
//   clk      in  1   system clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   request, only honoured in IDLE
//   var_sel  in  1   1: shamt = B[4:0] (SLLV), 0: shamt = B[10:6] (SLL)
//   A        in  32  operand
//   B        in  32  shift-amount source
//   busy     out 1   high while the FSM is outside IDLE
//   done     out 1   one-cycle pulse, o/ovf valid
//   o        out 32  A << shamt, zero-filled
//   ovf      out 1   signed overflow flag
module sll32_iter
    import sll_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              var_sel,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] o,
    output logic              ovf
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_o;
    logic               r_done;

    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_shifted;
    logic [SHAMT_W-1:0] w_used;
    logic [SHAMT_W-1:0] w_cntNext;
    logic               w_unusedB;

    // Only one 5-bit field of B matters for a given request; the rest is
    // folded into a deliberately unused wire.
    assign w_shamt   = var_sel ? B[SHAMT_VAR_LSB +: SHAMT_W] : B[SHAMT_FIX_LSB +: SHAMT_W];
    assign w_unusedB = &{1'b0, B[DATA_W-1:SHAMT_FIX_LSB+SHAMT_W], B[SHAMT_FIX_LSB-1:SHAMT_VAR_LSB+SHAMT_W]};
    assign w_cntNext = r_cnt - w_used;

`ifdef SLL32_ITER_OVF_EN
    logic r_ovfAcc;
    logic r_ovf;
    logic w_mismatch;

    sll_step #(
        .STEP       (STEP)
    ) u_step (
        .i_val      (r_acc),
        .i_cnt      (r_cnt),
        .o_val      (w_shifted),
        .o_used     (w_used),
        .o_mismatch (w_mismatch)
    );

    // Overflow is sticky across SHIFT iterations: once any iteration sees a
    // bit disagree with the sign, the full shift cannot be representable.
    // It is cleared on accept so a zero-length shift reports no overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfAcc <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_ovfAcc <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_ovfAcc <= r_ovfAcc | w_mismatch;
            end
            if (r_state == DONE) begin
                r_ovf <= r_ovfAcc;
            end
        end
    end

    assign ovf = r_ovf;
`else
    sll_step #(
        .STEP   (STEP)
    ) u_step (
        .i_val  (r_acc),
        .i_cnt  (r_cnt),
        .o_val  (w_shifted),
        .o_used (w_used)
    );

    assign ovf = 1'b0;
`endif

    // Main control FSM plus accumulator/counter. done is registered from the
    // DONE state, so it rises together with the o update and the return to
    // IDLE; that is what allows a back-to-back start in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_o     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= A;
                        r_cnt   <= w_shamt;
                        r_state <= (w_shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= w_cntNext;
                    if (w_cntNext == '0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_o     <= r_acc;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign o    = r_o;

endmodule

// File: doc/sll32_iter.md
# sll32_iter

Iterative 32-bit shift-left unit for the ALU's SLL/SLLV path: the left-shift counterpart of the single-cycle arithmetic right shifter. It accepts an operand and shift amount on a start pulse, shifts up to STEP bit positions per clock, and presents the result with a one-cycle done pulse. It sits beside the ALU and stalls the EX stage while busy is high.

## Interface
- STEP, 4, bits shifted per SHIFT cycle; power of two, 1..16
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- var_sel  in  1  1: shamt = B[4:0] (SLLV); 0: shamt = B[10:6] (SLL)
- A  in  32  operand
- B  in  32  shift-amount source
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; o and ovf valid
- o  out  32  result A << shamt, zero-filled
- ovf  out  1  signed overflow flag (see Configuration)

## Operation
- FSM: IDLE, SHIFT, DONE. Internal: acc[31:0], cnt[4:0], o, ovf regs.
- IDLE & start: acc<=A, cnt<=shamt; next SHIFT if shamt!=0, else DONE.
- IDLE & !start: hold.
- SHIFT: s=min(cnt,STEP); acc<=acc<<s; cnt<=cnt-s; next DONE when cnt-s==0, else stay.
- DONE: o<=acc, ovf<=computed flag, done=1 for this cycle; next IDLE unconditionally.
- start while busy: ignored, no queueing; A/B/var_sel need only be valid on the accepted start cycle.
- shamt width 5 bits; bits of B outside the selected field ignored. Shifted-out bits discarded.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, o=0, ovf=0, acc=0, cnt=0.
- Accept at cycle 0. shamt=0: done at cycle 1. shamt=n>0: done at cycle ceil(n/STEP)+1.
- o and ovf registered; change only on DONE entry; hold until next DONE.
- done is a registered decode of state DONE; IDLE is re-entered the cycle after, so back-to-back start in that cycle is accepted.
- Reset mid-operation aborts; no done pulse; o returns to 0.

## Configuration
- SLL32_ITER_OVF_EN defined: ovf=1 iff A[31:31-shamt] not all equal (A*2^shamt not representable as signed 32-bit); tracked per SHIFT cycle from shifted-out bits and the current sign bit; ovf=0 for shamt=0.
- Undefined: ovf port present but tied 0; tracking logic absent. All other behaviour identical.

## Structure
- Package sll_pkg: state enum (IDLE, SHIFT, DONE), SHAMT_W=5, DATA_W=32, field positions (SHAMT_FIX_LSB=6, SHAMT_VAR_LSB=0).
- One sub-module sll_step: combinational shift of 32-bit value by 0..STEP, outputs shifted value and mismatch flag (any shifted-out bit or new sign differs from old sign). FSM/counter in sll32_iter.

## Test plan
- STEP=4, var_sel=0, A=0x00000001, B[10:6]=31 -> o=0x80000000, done at cycle 9, ovf=1 (macro on).
- A=0xDEADBEEF, shamt=0 -> o=0xDEADBEEF, done at cycle 1, ovf=0, no SHIFT state visited.
- var_sel=1, B=0xFFFFFFE4, A=0x12345678 -> o=0x23456780, done at cycle 2, ovf=1; B[10:6] ignored.
- A=0xFFFFFFFF, shamt=8 -> o=0xFFFFFF00, ovf=0; second start pulsed at cycle 1 ignored, single done.
- rst_n low at cycle 3 of a 31-bit shift -> busy=0, o=0, no done; fresh start after release gives correct result.
- Back-to-back: start accepted on the cycle after done -> second result correct; first o held until second DONE.
